busdemux4x4_reg: RTL

Registered 1-to-4 bus demultiplexer with per-channel valid/ack handshake. It is the write-side counterpart of the one-hot 4x4 bus multiplexer: it takes a single 4-bit source bus and steers each word to one of four destination channels, using the same one-hot select encoding. Each channel has a one-word holding register, so consumers may accept data at their own pace. Input is back-pressured per channel. Malformed selects are detected, dropped and counted.

---
 rtl/busdemux4x4_reg_if.sv | 31 +++
 rtl/busdemux4x4_reg.sv | 103 ++++++++++
 2 files changed

// File: rtl/busdemux4x4_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : busdemux4x4_reg_if
// Brief    : Source and consumer bus bundle for the registered 1-to-4 demux.
// Revision : 1.0
// ============================================================================
interface busdemux4x4_reg_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0]   in_bus;
   logic               in_valid;
   logic [3:0]         sel;
   logic               in_ready;
   logic [4*WIDTH-1:0] out_bus;
   logic [3:0]         out_valid;
   logic [3:0]         out_ack;
   logic               err;
   logic [7:0]         drop_cnt;

   // master is the source plus the four consumers; slave is the demux itself
   modport master (
      output in_bus, in_valid, sel, out_ack,
      input  in_ready, out_bus, out_valid, err, drop_cnt
   );

   modport slave (
      input  in_bus, in_valid, sel, out_ack,
      output in_ready, out_bus, out_valid, err, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/busdemux4x4_reg.sv
`default_nettype none
// ============================================================================
// Module   : busdemux4x4_reg
// Brief    : Registered one-hot 1-to-4 bus demux with per-channel holding
//            registers, valid/ack handshake and malformed-select drop counter.
// Revision : 1.0
// ============================================================================
module busdemux4x4_reg #(
   parameter int WIDTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   busdemux4x4_reg_if.slave      bus
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   localparam logic [7:0] C_DROP_MAX = 8'hFF;

   chan_state_t      r_state    [4];
   chan_state_t      w_state_nxt[4];
   logic [WIDTH-1:0] r_data     [4];
   logic [WIDTH-1:0] w_data_nxt [4];

   logic       r_err;
   logic [7:0] r_drop_cnt;

   logic       w_legal;
   logic [3:0] w_full;
   logic [3:0] w_slot_free;
   logic       w_ready;
   logic       w_accept;
   logic       w_drop;
   logic [3:0] w_write;
   logic [3:0] w_take;

   // Legal select is exactly one bit set; zero and multi-hot are both dropped.
   always_comb begin
      w_legal     = (bus.sel != 4'd0) && ((bus.sel & (bus.sel - 4'd1)) == 4'd0);
      w_slot_free = ~w_full | bus.out_ack;
      w_ready     = w_legal ? |(bus.sel & w_slot_free) : 1'b1;
      w_accept    = bus.in_valid && w_ready;
      w_drop      = w_accept && !w_legal;
      w_write     = (w_accept && w_legal) ? bus.sel : 4'd0;
      w_take      = w_full & bus.out_ack;
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_state_nxt[k] = r_state[k];
         w_data_nxt[k]  = r_data[k];
         // A write on the same edge as an ack refills the slot with no gap.
         if (w_write[k]) begin
            w_state_nxt[k] = FULL;
            w_data_nxt[k]  = bus.in_bus;
         end else if (w_take[k]) begin
            w_state_nxt[k] = EMPTY;
            w_data_nxt[k]  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            r_state[k] <= EMPTY;
            r_data[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            r_state[k] <= w_state_nxt[k];
            r_data[k]  <= w_data_nxt[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err      <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else begin
         r_err <= w_drop;
         if (w_drop && (r_drop_cnt != C_DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_chan
      assign w_full[k]                        = (r_state[k] == FULL);
      assign bus.out_valid[k]                 = w_full[k];
      assign bus.out_bus[WIDTH*k +: WIDTH]    = r_data[k] & {WIDTH{w_full[k]}};
   end

   assign bus.in_ready = w_ready;
   assign bus.err      = r_err;
   assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
